// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU result (A) and load data (B); the granted write is registered one cycle.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  a_valid_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic                  a_ready_o,
    input  logic                  b_valid_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  b_ready_o,
    output logic                  Reg_Write_o,
    output logic [ADDR_WIDTH-1:0] Write_Register_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic                  last_grant_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t                 state_q;
    prio_t                 state_d;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Priority state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PRIO_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decision and next priority; nothing is granted during reset or stall
    always_comb begin
        a_ready_o = 1'b0;
        b_ready_o = 1'b0;
        state_d   = state_q;
        if (!reset && !stall_i) begin
            if (a_valid_i && (!b_valid_i || state_q == PRIO_A)) begin
                a_ready_o = 1'b1;
                state_d   = PRIO_B;
            end else if (b_valid_i) begin
                b_ready_o = 1'b1;
                state_d   = PRIO_A;
            end
        end
    end

    assign grant    = a_ready_o | b_ready_o;
    assign sel_addr = b_ready_o ? b_addr_i : a_addr_i;
    assign sel_data = b_ready_o ? b_data_i : a_data_i;

    // Registered write port; register-0 writes are swallowed and counted
    always_ff @(posedge clk) begin
        if (reset) begin
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
            last_grant_o     <= 1'b0;
            drop_cnt_o       <= '0;
        end else begin
            Reg_Write_o <= grant && (sel_addr != ADDR_ZERO);
            if (grant) begin
                last_grant_o <= b_ready_o;
                if (sel_addr != ADDR_ZERO) begin
                    Write_Register_o <= sel_addr;
                    Write_Data_o     <= sel_data;
                end else if (drop_cnt_o != CNT_MAX) begin
                    drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
